// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - core, cache-array and memory-bus signals of the data-cache controller
interface dcache_ctrl_if #(
  parameter int IDX_BITS     = 5,
  parameter int TAG_BITS     = 8,
  parameter int MEM_TAG_BITS = 4
);
  logic                    req_valid;
  logic                    req_wr;
  logic [63:0]             req_addr;
  logic [63:0]             req_data;
  logic                    req_ready;
  logic                    rsp_valid;
  logic [63:0]             rsp_data;

  logic                    dc_en;
  logic                    dc_wr_en;
  logic [IDX_BITS-1:0]     dc_wr_idx;
  logic [TAG_BITS-1:0]     dc_wr_tag;
  logic [63:0]             dc_wr_data;
  logic [IDX_BITS-1:0]     dc_rd_idx;
  logic [TAG_BITS-1:0]     dc_rd_tag;
  logic [63:0]             dc_rd_data;
  logic                    dc_rd_valid;

  logic [1:0]              proc2mem_command;
  logic [63:0]             proc2mem_addr;
  logic [63:0]             proc2mem_data;
  logic [MEM_TAG_BITS-1:0] mem2proc_response;
  logic [63:0]             mem2proc_data;
  logic [MEM_TAG_BITS-1:0] mem2proc_tag;

  modport slave (
    input  req_valid, req_wr, req_addr, req_data,
    output req_ready, rsp_valid, rsp_data,
    output dc_en, dc_wr_en, dc_wr_idx, dc_wr_tag, dc_wr_data, dc_rd_idx, dc_rd_tag,
    input  dc_rd_data, dc_rd_valid,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag
  );

  modport master (
    output req_valid, req_wr, req_addr, req_data,
    input  req_ready, rsp_valid, rsp_data,
    input  dc_en, dc_wr_en, dc_wr_idx, dc_wr_tag, dc_wr_data, dc_rd_idx, dc_rd_tag,
    output dc_rd_data, dc_rd_valid,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag
  );
endinterface

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - blocking write-through, write-allocate data-cache controller
module dcache_ctrl #(
  parameter int IDX_BITS     = 5,
  parameter int TAG_BITS     = 8,
  parameter int MEM_TAG_BITS = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  dcache_ctrl_if.slave bus
);
  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  typedef enum logic [1:0] {IDLE, LD_REQ, LD_WAIT, ST_REQ} state_t;

  state_t                  state;
  logic [63:3]             addr_q;
  logic                    wr_q;
  logic [63:0]             data_q;
  logic [MEM_TAG_BITS-1:0] miss_tag;
  logic                    rsp_valid_q;
  logic [63:0]             rsp_data_q;

  logic accept;
  logic tag_hit;
  logic st_ack;

  assign accept  = bus.req_valid && (state == IDLE);
  // A zero miss tag means no load is outstanding, so a reply tagged 0 never completes a miss.
  assign tag_hit = (state == LD_WAIT) && (miss_tag != '0) && (bus.mem2proc_tag == miss_tag);
  assign st_ack  = (state == ST_REQ) && (bus.mem2proc_response != '0);

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  assign bus.dc_rd_idx  = bus.req_addr[IDX_BITS+2:3];
  assign bus.dc_rd_tag  = bus.req_addr[TAG_BITS+IDX_BITS+2:IDX_BITS+3];
  assign bus.dc_wr_idx  = addr_q[IDX_BITS+2:3];
  assign bus.dc_wr_tag  = addr_q[TAG_BITS+IDX_BITS+2:IDX_BITS+3];
  // Stores allocate their own data; load fills take the memory reply.
  assign bus.dc_wr_data = wr_q ? data_q : bus.mem2proc_data;

  assign bus.proc2mem_addr = {addr_q, 3'b000};
  assign bus.proc2mem_data = data_q;

  always_comb begin
    bus.dc_en            = 1'b0;
    bus.dc_wr_en         = 1'b0;
    bus.proc2mem_command = CMD_NONE;
    case (state)
      IDLE:    bus.dc_en = bus.req_valid;
      LD_REQ:  bus.proc2mem_command = CMD_LOAD;
      LD_WAIT: begin
        bus.dc_en    = tag_hit;
        bus.dc_wr_en = tag_hit;
      end
      ST_REQ:  begin
        bus.proc2mem_command = CMD_STORE;
        bus.dc_en            = st_ack;
        bus.dc_wr_en         = st_ack;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      data_q      <= '0;
      miss_tag    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q <= bus.req_addr[63:3];
            wr_q   <= bus.req_wr;
            data_q <= bus.req_data;
            if (bus.req_wr) begin
              state <= ST_REQ;
            end else if (bus.dc_rd_valid) begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= bus.dc_rd_data;
            end else begin
              state <= LD_REQ;
            end
          end
        end
        LD_REQ: begin
          if (bus.mem2proc_response != '0) begin
            miss_tag <= bus.mem2proc_response;
            state    <= LD_WAIT;
          end
        end
        LD_WAIT: begin
          if (tag_hit) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= bus.mem2proc_data;
            state       <= IDLE;
          end
        end
        ST_REQ: begin
          if (st_ack) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
